// File: rtl/muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer bundle: instruction request in, stall/done and HI/LO out.
// The EX stage drives the master side; the sequencer implements the slave side.
interface muldiv_seq_if;
  logic        start;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, flush, funct, operand_1, operand_2,
    input  stall_req, done, hi, lo
  );

  modport slave (
    input  start, flush, funct, operand_1, operand_2,
    output stall_req, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// HI/LO owner running 1-cycle MULT/MULTU and 32-step restoring DIV/DIVU; done at T+2 (mul), T+34 (div), T+1 (div by 0).
// Backpressure: stall_req holds IF/ID/EX from acceptance until the DONE cycle; flush aborts to IDLE with no write.
module muldiv_seq #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [4:0] CNT_LAST = 5'(DIV_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] op_a, op_b, rem, quot, hi_q, lo_q;
  logic        mul_sgn, neg_q, neg_r, done_q;

  logic        is_mul, is_div, div_zero;
  logic [31:0] dividend_abs, divisor_abs;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] rem_sh;
  logic        take;
  logic [31:0] rem_sub;

  assign is_mul   = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
  assign is_div   = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign div_zero = (bus.operand_2 == 32'd0);

  assign dividend_abs = ((bus.funct == F_DIV) && bus.operand_1[31]) ? -bus.operand_1 : bus.operand_1;
  assign divisor_abs  = ((bus.funct == F_DIV) && bus.operand_2[31]) ? -bus.operand_2 : bus.operand_2;

  // Sign-extending by the latched flag lets one unsigned 64-bit multiply serve both MULT and MULTU.
  assign mul_a   = {{32{mul_sgn & op_a[31]}}, op_a};
  assign mul_b   = {{32{mul_sgn & op_b[31]}}, op_b};
  assign product = mul_a * mul_b;

  // The bit shifted out of rem is kept so divisors >= 2^31 still compare correctly.
  assign rem_sh  = {rem, quot[31]};
  assign take    = (rem_sh >= {1'b0, op_b});
  assign rem_sub = rem_sh[31:0] - op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.stall_req = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (is_mul) begin
            state_nxt = S_MUL;
          end else if (is_div) begin
            state_nxt = div_zero ? S_DONE : S_DIV;
          end
        end
        bus.stall_req = bus.start & (is_mul | is_div);
      end
      S_MUL: begin
        state_nxt     = S_DONE;
        bus.stall_req = 1'b1;
      end
      S_DIV: begin
        if (cnt == CNT_LAST) begin
          state_nxt = S_FIX;
        end
        bus.stall_req = 1'b1;
      end
      S_FIX: begin
        state_nxt     = S_DONE;
        bus.stall_req = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (bus.flush) begin
      state_nxt     = S_IDLE;
      bus.stall_req = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rem     <= '0;
      quot    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_nxt == S_DONE);
      if (!bus.flush) begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              case (bus.funct)
                F_MULT, F_MULTU: begin
                  op_a    <= bus.operand_1;
                  op_b    <= bus.operand_2;
                  mul_sgn <= (bus.funct == F_MULT);
                end
                F_DIV, F_DIVU: begin
                  if (!div_zero) begin
                    quot  <= dividend_abs;
                    op_b  <= divisor_abs;
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= (bus.funct == F_DIV) & (bus.operand_1[31] ^ bus.operand_2[31]);
                    neg_r <= (bus.funct == F_DIV) & bus.operand_1[31];
                  end
                end
                F_MTHI:  hi_q <= bus.operand_1;
                F_MTLO:  lo_q <= bus.operand_1;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            {hi_q, lo_q} <= product;
          end
          S_DIV: begin
            rem  <= take ? rem_sub : rem_sh[31:0];
            quot <= {quot[30:0], take};
            cnt  <= cnt + 5'd1;
          end
          S_FIX: begin
            lo_q <= neg_q ? -quot : quot;
            hi_q <= neg_r ? -rem : rem;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed cases plus randomized ops checked against an arithmetic HI/LO model.
module tb_muldiv_seq;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] exp_hi, exp_lo;

  muldiv_seq_if bus();

  muldiv_seq #(.DIV_ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: HI/LO after an op, computed with plain integer arithmetic.
  task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    case (f)
      F_MULT:  begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      F_MULTU: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      F_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      F_DIVU:  if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      F_MTHI:  exp_hi = a;
      F_MTLO:  exp_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_stalls(input logic [5:0] f, input logic [31:0] b);
    if (f == F_MULT || f == F_MULTU) return 2;
    if (f == F_DIV || f == F_DIVU) return (b == 0) ? 1 : 34;
    return 0;
  endfunction

  function automatic int exp_done_at(input logic [5:0] f, input logic [31:0] b);
    if (f == F_MULT || f == F_MULTU) return 2;
    if (f == F_DIV || f == F_DIVU) return (b == 0) ? 1 : 34;
    return -1;
  endfunction

  // Issue one instruction in EX and hold start until stall_req drops (EX advances).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int done_at, output int n_done,
                        output bit timeout, output logic [31:0] h, output logic [31:0] l);
    logic s;
    stalls = 0; done_at = -1; n_done = 0; timeout = 1'b1; h = '0; l = '0;
    bus.start = 1'b1; bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      s = bus.stall_req;
      if (bus.done) begin n_done++; done_at = c; h = bus.hi; l = bus.lo; end
      if (s) stalls++;
      @(posedge clk); #1;
      if (!s) begin timeout = 1'b0; break; end
    end
    bus.start = 1'b0;
    if (done_at < 0) begin h = bus.hi; l = bus.lo; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.flush = 1'b0; bus.funct = '0;
    bus.operand_1 = '0; bus.operand_2 = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int st, da, nd; bit to; logic [31:0] h, l;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, st, da, nd, to, h, l);
    model_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    checks += 5;
    if (to || st != 2) begin failures++; $display("FAIL mult_stalls got=%0d exp=2 timeout=%0d", st, to); end
    if (da != 2 || nd != 1) begin failures++; $display("FAIL mult_done got_at=%0d n=%0d exp_at=2 n=1", da, nd); end
    if (h !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", h); end
    if (l !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffeb", l); end
    if (h !== exp_hi) begin failures++; $display("FAIL mult_model_hi got=%h exp=%h", h, exp_hi); end
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'd2, st, da, nd, to, h, l);
    model_op(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    checks += 3;
    if (to || st != 2 || da != 2) begin failures++; $display("FAIL multu_timing got_st=%0d got_da=%0d exp=2/2", st, da); end
    if (h !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", h); end
    if (l !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", l); end
  endtask

  task automatic test_div;
    int st, da, nd; bit to; logic [31:0] h, l;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, st, da, nd, to, h, l);
    model_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    checks += 4;
    if (to || st != 34) begin failures++; $display("FAIL div_stalls got=%0d exp=34 timeout=%0d", st, to); end
    if (da != 34 || nd != 1) begin failures++; $display("FAIL div_done got_at=%0d n=%0d exp_at=34 n=1", da, nd); end
    if (l !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", l); end
    if (h !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", h); end
    run_op(F_DIVU, 32'd100, 32'd7, st, da, nd, to, h, l);
    model_op(F_DIVU, 32'd100, 32'd7);
    checks += 2;
    if (l !== 32'd14) begin failures++; $display("FAIL divu_lo got=%0d exp=14", l); end
    if (h !== 32'd2) begin failures++; $display("FAIL divu_hi got=%0d exp=2", h); end
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, da, nd, to, h, l);
    model_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checks += 2;
    if (l !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", l); end
    if (h !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", h); end
  endtask

  task automatic test_div_zero;
    int st, da, nd; bit to; logic [31:0] h, l;
    run_op(F_DIVU, 32'h1234, 32'd0, st, da, nd, to, h, l);
    checks += 3;
    if (to || st != 1) begin failures++; $display("FAIL div0_stalls got=%0d exp=1", st); end
    if (da != 1 || nd != 1) begin failures++; $display("FAIL div0_done got_at=%0d n=%0d exp_at=1 n=1", da, nd); end
    if (h !== 32'h0 || l !== 32'h8000_0000) begin
      failures++; $display("FAIL div0_hilo got=%h/%h exp=00000000/80000000", h, l);
    end
  endtask

  task automatic test_mt_ignored;
    int st, da, nd; bit to; logic [31:0] h, l;
    run_op(F_MTLO, 32'hCAFE_F00D, 32'd5, st, da, nd, to, h, l);
    model_op(F_MTLO, 32'hCAFE_F00D, 32'd5);
    checks += 3;
    if (to || st != 0) begin failures++; $display("FAIL mtlo_stalls got=%0d exp=0", st); end
    if (nd != 0) begin failures++; $display("FAIL mtlo_done got=%0d exp=0", nd); end
    if (l !== 32'hCAFE_F00D || h !== exp_hi) begin failures++; $display("FAIL mtlo_val got=%h/%h exp=%h/cafef00d", h, l, exp_hi); end
    run_op(6'h20, 32'h5555_5555, 32'd3, st, da, nd, to, h, l);
    checks += 2;
    if (to || st != 0 || nd != 0) begin failures++; $display("FAIL other_funct got_st=%0d got_n=%0d exp=0/0", st, nd); end
    if (h !== exp_hi || l !== exp_lo) begin failures++; $display("FAIL other_funct_hilo got=%h/%h exp=%h/%h", h, l, exp_hi, exp_lo); end
  endtask

  task automatic test_flush;
    int st, da, nd; bit to, stall_ok, no_done; logic [31:0] h, l;
    run_op(F_MTHI, 32'h1234_5678, 32'd0, st, da, nd, to, h, l);
    model_op(F_MTHI, 32'h1234_5678, 32'd0);
    checks += 1;
    if (h !== 32'h1234_5678 || st != 0) begin failures++; $display("FAIL mthi got=%h stalls=%0d exp=12345678/0", h, st); end
    bus.start = 1'b1; bus.funct = F_DIV; bus.operand_1 = 32'd10; bus.operand_2 = 32'd3;
    stall_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.stall_req || bus.done) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    checks += 2;
    if (!stall_ok) begin failures++; $display("FAIL flush_prestall got=0 exp=1"); end
    if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_req); end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    no_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.stall_req) no_done = 1'b0;
    end
    checks += 2;
    if (!no_done) begin failures++; $display("FAIL flush_nodone got=1 exp=0"); end
    if (bus.hi !== 32'h1234_5678 || bus.lo !== exp_lo) begin
      failures++; $display("FAIL flush_hilo got=%h/%h exp=12345678/%h", bus.hi, bus.lo, exp_lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int st, da, nd; bit to; logic [31:0] h, l;
    bus.start = 1'b1; bus.funct = F_DIVU; bus.operand_1 = 32'd10; bus.operand_2 = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; bus.start = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0;
    checks += 2;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin failures++; $display("FAIL rstmid_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
    if (bus.done !== 1'b0 || bus.stall_req !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctl got_done=%b got_stall=%b exp=0/0", bus.done, bus.stall_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(F_DIVU, 32'd100, 32'd7, st, da, nd, to, h, l);
    model_op(F_DIVU, 32'd100, 32'd7);
    checks += 1;
    if (to || st != 34 || l !== 32'd14 || h !== 32'd2) begin
      failures++; $display("FAIL rstmid_after got_st=%0d got=%h/%h exp=34/00000002/0000000e", st, h, l);
    end
  endtask

  task automatic test_random;
    int st, da, nd; bit to; logic [31:0] h, l, a, b; logic [5:0] f; int sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      f = (sel == 0) ? F_MULT : (sel == 1) ? F_MULTU : (sel == 2) ? F_DIV : F_DIVU;
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(f, a, b, st, da, nd, to, h, l);
      model_op(f, a, b);
      checks += 3;
      if (to || st != exp_stalls(f, b)) begin
        failures++; $display("FAIL rand_stalls f=%h a=%h b=%h got=%0d exp=%0d", f, a, b, st, exp_stalls(f, b));
      end
      if (da != exp_done_at(f, b) || nd != 1) begin
        failures++; $display("FAIL rand_done f=%h got_at=%0d n=%0d exp_at=%0d", f, da, nd, exp_done_at(f, b));
      end
      if (h !== exp_hi || l !== exp_lo) begin
        failures++; $display("FAIL rand_hilo f=%h a=%h b=%h got=%h/%h exp=%h/%h", f, a, b, h, l, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int st, da, nd; bit to; logic [31:0] h, l, a, b; logic [5:0] f; int sel;
    for (int i = 0; i < 12; i++) begin
      sel = $urandom_range(0, 5);
      f = (sel == 0) ? F_MULT : (sel == 1) ? F_MULTU : (sel == 2) ? F_DIV :
          (sel == 3) ? F_DIVU : (sel == 4) ? F_MTHI : F_MTLO;
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
      run_op(f, a, b, st, da, nd, to, h, l);
      model_op(f, a, b);
      checks += 2;
      if (to || st != exp_stalls(f, b) || da != exp_done_at(f, b)) begin
        failures++; $display("FAIL b2b_timing f=%h got_st=%0d got_da=%0d exp=%0d/%0d", f, st, da, exp_stalls(f, b), exp_done_at(f, b));
      end
      if (h !== exp_hi || l !== exp_lo) begin
        failures++; $display("FAIL b2b_hilo f=%h a=%h b=%h got=%h/%h exp=%h/%h", f, a, b, h, l, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mt_ignored();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
